bch_dec_ctrl: RTL
=================

# bch_dec_ctrl

Sequencer for the BCH(15,7) t=2 decode datapath. It accepts received codewords over a valid/ready handshake and drives the syndrome, key-equation (lambda) and Chien-search stages in order with start/done handshakes. It checks the located errors against the locator degree, applies the correction, and presents the corrected word with a status code. It sits between the channel/error-injection front end and the message consumer, replacing free-running stage chaining with one-frame-in-flight control.

## Interface
- STAGE_TIMEOUT, 64: max cycles to wait for any stage done before aborting the frame (>=2).
- CNT_W, 16: width of statistics counters (used only with BCH_CTRL_STATS_EN).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  received codeword valid.
- in_ready  out  1  controller can accept a codeword.
- in_codeword  in  15  received (possibly corrupted) codeword.
- syn_start  out  1  one-cycle pulse: syndrome stage begins on syn_word.
- syn_word  out  15  captured codeword, held stable for the whole frame.
- syn_done  in  1  syndromes valid.
- S1, S2, S3  in  4 each  GF(2^4) syndromes, sampled when syn_done=1.
- key_start  out  1  one-cycle pulse: lambda computation begins.
- key_done  in  1  lambda valid.
- lambda1, lambda2  in  4 each  locator coefficients, sampled when key_done=1.
- chien_start  out  1  one-cycle pulse: Chien search begins.
- chien_done  in  1  error vector valid.
- error_vector  in  15  located error positions, sampled when chien_done=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_codeword  out  15  corrected codeword (or raw word if not corrected).
- out_status  out  2  0=clean, 1=corrected, 2=uncorrectable, 3=stage timeout.
- out_nerr  out  2  number of errors corrected (0..2).

## Operation
- FSM states: IDLE, SYND, KEY, SEARCH, CORR, OUT.
- IDLE: in_ready=1. On in_valid, capture in_codeword into syn_word and go to SYND.
- SYND: syn_start=1 in the first cycle only. Wait for syn_done. If S1=S2=S3=0, go to OUT with status 0, nerr 0, data=syn_word. Otherwise go to KEY.
- KEY: key_start is pulsed in the first cycle. On key_done, compute deg = 2 if lambda2!=0, else 1 if lambda1!=0, else 0. If deg=0, go to OUT with status 2. Otherwise go to SEARCH.
- SEARCH: chien_start is pulsed in the first cycle. On chien_done, register error_vector and go to CORR.
- CORR (1 cycle): w = popcount(error_vector), 0..15.
  - If w==deg: data=syn_word^error_vector, status 1, nerr=deg.
  - Otherwise: data=syn_word, status 2, nerr 0.
- OUT: out_valid=1. Outputs are held stable until out_valid&&out_ready, then return to IDLE.
- Done inputs are ignored outside their own state and in the start cycle.
- Timeout: a counter is cleared on entering SYND, KEY or SEARCH. If it reaches STAGE_TIMEOUT with no done, go to OUT with status 3, data=syn_word, nerr 0.
- Reset: state=IDLE, counters 0, syn_word=0. All outputs are 0 except in_ready=1.

## Timing
- Frame accepted at edge N: SYND entered at N+1, with syn_start high during cycle N+1.
- Done is sampled from cycle N+2 onward.
- Clean path with syn_done at N+2: out_valid asserts in cycle N+3.
- Error path with every done asserted in the cycle after its start: out_valid asserts in cycle N+8 (SYND 2, KEY 2, SEARCH 2, CORR 1).
- in_ready is combinational from the state (IDLE only). No input overlap: one frame in flight.
- in_valid while not in IDLE is ignored; the source must hold it.
- out_valid&&out_ready in OUT → IDLE next cycle, in_ready=1. No back-to-back bypass.
- rst asserted mid-frame aborts the frame: no out_valid, and start pulses are suppressed from the next edge.

## Configuration
- BCH_CTRL_STATS_EN defined: adds outputs stat_frames, stat_corrected, stat_uncorr, stat_timeout (each CNT_W wide).
  - Each increments on the out_valid&&out_ready handshake according to out_status.
  - Counters saturate at all-ones and are cleared by rst.
- BCH_CTRL_STATS_EN undefined: these ports and registers are absent. All other behaviour is identical.

## Test plan
- Clean word 15'h0000 with syn_done one cycle after syn_start and S=0,0,0 → out_valid in cycle N+3, status 0, data 15'h0000, key_start never pulses.
- Word with 15'h0001 flipped; stub returns S1=1, lambda1=1, lambda2=0, error_vector=15'h0001 → status 1, nerr 1, data = original codeword.
- Two-bit error; stub returns lambda2!=0, error_vector with 2 bits set → status 1, nerr 2; same stub with error_vector of 1 bit set → status 2, data=raw word.
- syn_done held low → status 3 exactly STAGE_TIMEOUT cycles after SYND entry; in_ready=0 throughout.
- out_ready held low for 10 cycles → out_codeword/out_status stable; a new in_valid is not accepted until one cycle after the handshake.
- rst pulsed during SEARCH → in_ready=1 and out_valid=0 next cycle; a following frame decodes normally. With BCH_CTRL_STATS_EN, counters read 0 after rst.

Source files
------------

// File: rtl/bch_dec_ctrl.sv
// bch_dec_ctrl: one-frame-in-flight sequencer for the BCH(15,7) t=2 decoder.
// Runs the syndrome, key-equation and Chien stages in order using start/done
// handshakes. It checks the located error count against the locator degree,
// applies the correction and holds the result until the consumer takes it.
// Optional build macro: BCH_CTRL_STATS_EN adds saturating statistics counters.
module bch_dec_ctrl #(
  parameter int unsigned STAGE_TIMEOUT = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [14:0]       in_codeword,
  output logic              syn_start,
  output logic [14:0]       syn_word,
  input  logic              syn_done,
  input  logic [3:0]        S1,
  input  logic [3:0]        S2,
  input  logic [3:0]        S3,
  output logic              key_start,
  input  logic              key_done,
  input  logic [3:0]        lambda1,
  input  logic [3:0]        lambda2,
  output logic              chien_start,
  input  logic              chien_done,
  input  logic [14:0]       error_vector,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [14:0]       out_codeword,
  output logic [1:0]        out_status,
  output logic [1:0]        out_nerr
`ifdef BCH_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_frames,
  output logic [CNT_W-1:0]  stat_corrected,
  output logic [CNT_W-1:0]  stat_uncorr,
  output logic [CNT_W-1:0]  stat_timeout
`endif
);

  localparam int unsigned TW = $clog2(STAGE_TIMEOUT + 1);

  localparam logic [1:0] ST_CLEAN   = 2'd0;
  localparam logic [1:0] ST_CORR    = 2'd1;
  localparam logic [1:0] ST_UNCORR  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SYND,
    KEY,
    SEARCH,
    CORR,
    OUT
  } state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [14:0] word_q, word_d;
  logic [14:0] ev_q, ev_d;
  logic [1:0]  deg_q, deg_d;
  logic [14:0] ocw_q, ocw_d;
  logic [1:0]  ost_q, ost_d;
  logic [1:0]  onerr_q, onerr_d;

  logic        first_cyc;
  logic        tmo_hit;
  logic [1:0]  key_deg;
  logic [3:0]  popcnt;

  // The stage counter is cleared on stage entry, so zero marks the start cycle.
  assign first_cyc = (tcnt_q == '0);
  assign tmo_hit   = (tcnt_q == TW'(STAGE_TIMEOUT - 1));

  assign in_ready    = (state_q == IDLE);
  assign syn_start   = (state_q == SYND)   && first_cyc;
  assign key_start   = (state_q == KEY)    && first_cyc;
  assign chien_start = (state_q == SEARCH) && first_cyc;
  assign out_valid   = (state_q == OUT);
  assign syn_word     = word_q;
  assign out_codeword = ocw_q;
  assign out_status   = ost_q;
  assign out_nerr     = onerr_q;

  // Locator degree derived from the lambda coefficients.
  always_comb begin
    key_deg = 2'd0;
    if (lambda2 != '0)      key_deg = 2'd2;
    else if (lambda1 != '0) key_deg = 2'd1;
  end

  // Number of located error positions in the registered error vector.
  always_comb begin
    popcnt = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      popcnt = popcnt + 4'(ev_q[i]);
    end
  end

  // Next-state and result computation for the frame sequencer.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    word_d  = word_q;
    ev_d    = ev_q;
    deg_d   = deg_q;
    ocw_d   = ocw_q;
    ost_d   = ost_q;
    onerr_d = onerr_q;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (in_valid) begin
          word_d  = in_codeword;
          state_d = SYND;
        end
      end
      SYND: begin
        tcnt_d = tcnt_q + 1'b1;
        if (!first_cyc && syn_done) begin
          tcnt_d = '0;
          if (S1 == '0 && S2 == '0 && S3 == '0) begin
            state_d = OUT;
            ocw_d   = word_q;
            ost_d   = ST_CLEAN;
            onerr_d = 2'd0;
          end else begin
            state_d = KEY;
          end
        end else if (tmo_hit) begin
          state_d = OUT;
          ocw_d   = word_q;
          ost_d   = ST_TIMEOUT;
          onerr_d = 2'd0;
        end
      end
      KEY: begin
        tcnt_d = tcnt_q + 1'b1;
        if (!first_cyc && key_done) begin
          tcnt_d = '0;
          deg_d  = key_deg;
          if (key_deg == 2'd0) begin
            state_d = OUT;
            ocw_d   = word_q;
            ost_d   = ST_UNCORR;
            onerr_d = 2'd0;
          end else begin
            state_d = SEARCH;
          end
        end else if (tmo_hit) begin
          state_d = OUT;
          ocw_d   = word_q;
          ost_d   = ST_TIMEOUT;
          onerr_d = 2'd0;
        end
      end
      SEARCH: begin
        tcnt_d = tcnt_q + 1'b1;
        if (!first_cyc && chien_done) begin
          tcnt_d  = '0;
          ev_d    = error_vector;
          state_d = CORR;
        end else if (tmo_hit) begin
          state_d = OUT;
          ocw_d   = word_q;
          ost_d   = ST_TIMEOUT;
          onerr_d = 2'd0;
        end
      end
      CORR: begin
        state_d = OUT;
        if (popcnt == {2'b00, deg_q}) begin
          ocw_d   = word_q ^ ev_q;
          ost_d   = ST_CORR;
          onerr_d = deg_q;
        end else begin
          ocw_d   = word_q;
          ost_d   = ST_UNCORR;
          onerr_d = 2'd0;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      word_q  <= '0;
      ev_q    <= '0;
      deg_q   <= '0;
      ocw_q   <= '0;
      ost_q   <= '0;
      onerr_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      word_q  <= word_d;
      ev_q    <= ev_d;
      deg_q   <= deg_d;
      ocw_q   <= ocw_d;
      ost_q   <= ost_d;
      onerr_q <= onerr_d;
    end
  end

`ifdef BCH_CTRL_STATS_EN
  logic [CNT_W-1:0] frames_q, corr_q, uncorr_q, tmo_q;
  logic             hs;

  assign hs             = out_valid && out_ready;
  assign stat_frames    = frames_q;
  assign stat_corrected = corr_q;
  assign stat_uncorr    = uncorr_q;
  assign stat_timeout   = tmo_q;

  // Saturating per-status counters, advanced on each result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
      corr_q   <= '0;
      uncorr_q <= '0;
      tmo_q    <= '0;
    end else if (hs) begin
      if (frames_q != '1) frames_q <= frames_q + 1'b1;
      if (ost_q == ST_CORR    && corr_q   != '1) corr_q   <= corr_q + 1'b1;
      if (ost_q == ST_UNCORR  && uncorr_q != '1) uncorr_q <= uncorr_q + 1'b1;
      if (ost_q == ST_TIMEOUT && tmo_q    != '1) tmo_q    <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule
